// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a field bundle into a 32-bit word and
// streams encoded words sequentially into instruction memory.
module instr_encoder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [12:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-2:0] word_count,
  output logic              full,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W - 1;

  localparam logic [2:0] T_R      = 3'd0;
  localparam logic [2:0] T_IALU   = 3'd1;
  localparam logic [2:0] T_LOAD   = 3'd2;
  localparam logic [2:0] T_STORE  = 3'd3;
  localparam logic [2:0] T_BRANCH = 3'd4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENC   = 2'd1,
    S_WRITE = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         type_q;
  logic [4:0]         rd_q, rs1_q, rs2_q;
  logic [2:0]         f3_q;
  logic [6:0]         f7_q;
  logic [12:0]        imm_q;
  logic               cap_en;

  logic               ready_q, ready_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full_q, full_d;
  logic               err_q, err_d;

  logic               legal;
  logic [31:0]        enc_word;
  logic [CNT_W-1:0]   cnt_inc;

  // Legality: only the five known classes, and branch targets must be halfword aligned.
  always_comb begin
    legal = (type_q <= T_BRANCH);
    if (type_q == T_BRANCH && imm_q[0]) legal = 1'b0;
  end

  // Field packing for each instruction class.
  always_comb begin
    enc_word = 32'h0;
    case (type_q)
      T_R:      enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, OP_R};
      T_IALU:   enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_IALU};
      T_LOAD:   enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_LOAD};
      T_STORE:  enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OP_STORE};
      T_BRANCH: enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                            imm_q[4:1], imm_q[11], OP_BRANCH};
      default:  enc_word = 32'h0;
    endcase
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    err_d   = err_q;
    cap_en  = 1'b0;

    if (clear) begin
      state_d = S_IDLE;
      addr_d  = ADDR_W'(BASE_ADDR);
      cnt_d   = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            cap_en  = 1'b1;
            state_d = S_ENC;
          end
        end
        S_ENC: begin
          if (legal) begin
            wdata_d = enc_word;
            we_d    = 1'b1;
            state_d = S_WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_WRITE: begin
          cnt_d = cnt_inc;
          // Pointer parks on the last written address once memory is full.
          if (cnt_inc == CNT_W'(DEPTH_WORDS)) begin
            full_d  = 1'b1;
            state_d = S_FULL;
          end else begin
            addr_d  = addr_q + ADDR_W'(4);
            state_d = S_IDLE;
          end
        end
        S_FULL: begin
          full_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  // Captured field bundle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      type_q <= 3'd0;
      rd_q   <= 5'd0;
      rs1_q  <= 5'd0;
      rs2_q  <= 5'd0;
      f3_q   <= 3'd0;
      f7_q   <= 7'd0;
      imm_q  <= 13'd0;
    end else if (cap_en) begin
      type_q <= in_type;
      rd_q   <= in_rd;
      rs1_q  <= in_rs1;
      rs2_q  <= in_rs2;
      f3_q   <= in_funct3;
      f7_q   <= in_funct7;
      imm_q  <= in_imm;
    end
  end

  // A clear arriving during the write cycle must drop the word immediately.
  assign mem_we     = we_q & ~clear;
  assign in_ready   = ready_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = cnt_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Control-to-machine-code encoder: the writer counterpart of the main decoder.
- Accepts an instruction class plus register, funct and immediate fields over a valid/ready handshake.
- Packs these into a 32-bit RV32I word using the opcodes the decoder recognises.
- Writes words sequentially into instruction memory. Used for boot-time program loading and for self-test program generation ahead of the fetch stage.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words the target instruction memory holds.
- ADDR_W, 10, byte-address width; must equal log2(DEPTH_WORDS*4).
- BASE_ADDR, 0, byte address of the first word written after reset or clear.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-low reset
- clear  input  1  synchronous: abort in-flight word, write pointer to BASE_ADDR, clear full and err
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- in_type  input  3  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5-7 illegal
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3 field
- in_funct7  input  7  funct7 field (R only)
- in_imm  input  13  immediate, two's complement; bits 11:0 for I/S, 12:0 for B
- mem_we  output  1  instruction-memory write strobe, one cycle per word
- mem_addr  output  ADDR_W  byte address of write
- mem_wdata  output  32  encoded instruction
- word_count  output  ADDR_W-1  words written since reset/clear
- full  output  1  DEPTH_WORDS words written
- err  output  1  sticky; set on rejected bundle

Behaviour:
- Reset (rst=0 at clk edge) values:
  - state=IDLE, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, full=0, err=0.
  - Reset overrides clear and everything else, including a WRITE in progress: mem_we is 0 on the cycle after reset is sampled.
- FSM states: IDLE, ENC, WRITE, FULL.
- IDLE:
  - in_ready=1.
  - On in_valid, all fields are registered and the FSM moves to ENC.
- ENC:
  - in_ready=0.
  - Legal bundle: the word is computed into mem_wdata and the FSM moves to WRITE.
  - Illegal bundle (in_type 5-7, or BRANCH with imm[0]=1): err set, no write, pointer unchanged, FSM returns to IDLE.
- WRITE:
  - mem_we=1 for exactly this cycle; mem_addr=current pointer.
  - Next edge: pointer += 4, word_count += 1.
  - Next state is FULL if word_count reaches DEPTH_WORDS, otherwise IDLE.
- FULL:
  - full=1, in_ready=0; bundles are ignored, not errored.
  - Left only via clear or rst.
- Latency and throughput:
  - Bundle accepted at edge N; mem_we high during cycle N+2.
  - Peak rate is 1 word per 3 cycles.
- Pointer: no wrap-around. full blocks further writes, so mem_addr never exceeds BASE_ADDR+4*(DEPTH_WORDS-1).
- clear:
  - Acts in any state; returns to IDLE.
  - Simultaneous clear and in_valid in IDLE: clear wins, bundle not accepted.
  - clear in WRITE: mem_we forced 0 that cycle, word dropped.
- Encodings (bits 31..0, concatenated MSB first):
  - R: funct7 | rs2 | rs1 | funct3 | rd | 0110011
  - I-ALU: imm[11:0] | rs1 | funct3 | rd | 0010011
  - LOAD: imm[11:0] | rs1 | funct3 | rd | 0000011
  - STORE: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | 0100011
  - BRANCH: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | 1100011
- Field rules:
  - imm[12] is ignored for I/S.
  - Unused register fields are ignored, e.g. rd for STORE/BRANCH.
  - funct7 is ignored except for R.
- mem_wdata holds its last value when mem_we=0.

Test Plan:
- Reset, then R bundle rd=3 rs1=1 rs2=2 f3=0 f7=0 (add x3,x1,x2) -> mem_we at N+2, mem_addr=0x000, mem_wdata=0x002081B3, word_count=1.
- Then LOAD rd=5 rs1=2 f3=2 imm=8 (lw x5,8(x2)) -> mem_addr=0x004, mem_wdata=0x00812283. Then STORE rs2=5 rs1=2 f3=2 imm=12 (sw x5,12(x2)) -> mem_addr=0x008, mem_wdata=0x00512623.
- BRANCH rs1=1 rs2=2 f3=0 imm=0x1FFC (beq x1,x2,-4) -> mem_wdata=0xFE208EE3.
- BRANCH imm=0x0003 -> err=1, no mem_we, pointer/word_count unchanged. Follow with in_type=7 -> err stays 1, no write. clear -> err=0.
- DEPTH_WORDS=4: write 4 legal words -> full=1 and in_ready=0 after 4th write. 5th bundle held valid 10 cycles -> no mem_we. clear -> full=0, next word at mem_addr=BASE_ADDR.
- Drive rst=0 during WRITE cycle and separately clear during WRITE -> mem_we=0, word_count unchanged (reset: all outputs at reset values next cycle).
